// File: rtl/q_sys_fifo_pkg.sv
// Shared CSR map and status layout for the Avalon-MM fed output FIFO.
// Imported by the bus wrapper; the bench uses the same numeric values from its own constants.
package q_sys_fifo_pkg;

  typedef enum logic [1:0] {
    ADDR_DATA   = 2'd0,
    ADDR_STATUS = 2'd1,
    ADDR_CTRL   = 2'd2,
    ADDR_FLUSH  = 2'd3
  } csr_addr_e;

  localparam int STAT_USED_W     = 9;
  localparam int STAT_EMPTY_BIT  = 16;
  localparam int STAT_FULL_BIT   = 17;
  localparam int STAT_OVF_BIT    = 18;
  localparam int CTRL_WM_W       = 8;
  localparam int CTRL_IRQ_EN_BIT = 8;

  function automatic logic [31:0] pack_status(input logic [STAT_USED_W-1:0] used,
                                              input logic empty,
                                              input logic full,
                                              input logic overflow);
    logic [31:0] s;
    s                    = '0;
    s[STAT_USED_W-1:0]   = used;
    s[STAT_EMPTY_BIT]    = empty;
    s[STAT_FULL_BIT]     = full;
    s[STAT_OVF_BIT]      = overflow;
    return s;
  endfunction

endpackage

// File: rtl/q_sys_sc_fifo.sv
// Single-clock FIFO: storage array plus naturally wrapping pointers and a used counter.
// Flush wins over push and pop in the same cycle; a push while full is dropped.
module q_sys_sc_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_head,
  output logic [AW:0]       o_used,
  output logic              o_full,
  output logic              o_empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_used;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_used == FULL_CNT);
  assign o_empty   = (r_used == '0);
  assign o_used    = r_used;
  assign w_do_pop  = i_pop && !o_empty && !i_flush;
  assign w_do_push = i_push && !o_full && !i_flush;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_used <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_used <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_used <= r_used + (AW+1)'(1);
        2'b01:   r_used <= r_used - (AW+1)'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  // Storage is deliberately not reset; reset/flush only move the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

  assign o_head = r_mem[r_rptr];

endmodule

// File: rtl/q_sys_out_fifo_feed.sv
// Avalon-MM slave that pushes words into a FIFO drained by a valid/ready stream,
// with status/control CSRs and a registered low-watermark interrupt.
module q_sys_out_fifo_feed
  import q_sys_fifo_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              write,
  input  logic              read,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              irq
);

  localparam int AW = $clog2(DEPTH);

  logic                 r_ignore;
  logic [31:0]          r_readdata;
  logic                 r_overflow;
  logic [CTRL_WM_W-1:0] r_watermark;
  logic                 r_irq_en;
  logic                 r_irq;

  logic                   w_bus_en;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;
  logic                   w_ctrl_wr;
  logic [DATA_W-1:0]      w_head;
  logic [AW:0]            w_used;
  logic [STAT_USED_W-1:0] w_used9;
  logic                   w_full;
  logic                   w_empty;
  logic [31:0]            w_rd_mux;
  logic                   w_unused;

  // Held high through reset and for the first edge after release, so that edge sees no bus/stream activity.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_ignore <= 1'b1;
    else       r_ignore <= 1'b0;
  end

  assign w_bus_en  = !r_ignore;
  assign w_push    = w_bus_en && write && (address == ADDR_DATA);
  assign w_flush   = w_bus_en && write && (address == ADDR_FLUSH) && writedata[0];
  assign w_ctrl_wr = w_bus_en && write && (address == ADDR_CTRL);
  // Stream handshake: a word transfers on any edge where out_valid and out_ready are both high.
  assign w_pop     = w_bus_en && out_valid && out_ready;
  assign w_used9   = STAT_USED_W'(w_used);
  assign w_unused  = &{1'b0, writedata};

  q_sys_sc_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_data  (writedata[DATA_W-1:0]),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_used  (w_used),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_rd_mux = '0;
    case (address)
      ADDR_STATUS: w_rd_mux = pack_status(w_used9, w_empty, w_full, r_overflow);
      ADDR_CTRL:   w_rd_mux = {23'd0, r_irq_en, r_watermark};
      default:     w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_readdata  <= '0;
      r_overflow  <= 1'b0;
      r_watermark <= '0;
      r_irq_en    <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_readdata <= (read && w_bus_en) ? w_rd_mux : 32'd0;
      if (w_flush)                r_overflow <= 1'b0;
      else if (w_push && w_full)  r_overflow <= 1'b1;
      if (w_ctrl_wr) begin
        r_watermark <= writedata[CTRL_WM_W-1:0];
        r_irq_en    <= writedata[CTRL_IRQ_EN_BIT];
      end
      r_irq <= r_irq_en && (w_used9 <= {1'b0, r_watermark});
    end
  end

  assign readdata  = r_readdata;
  assign out_data  = w_head;
  assign out_valid = !w_empty;
  assign irq       = r_irq;

endmodule

// File: tb/tb_q_sys_out_fifo_feed.sv
// Bench for q_sys_out_fifo_feed: bus driver tasks, a stream scoreboard fed on every push,
// and one task per scenario with inline checks.
module tb_q_sys_out_fifo_feed;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic              clk;
  logic              reset;
  logic [1:0]        address;
  logic              write;
  logic              read;
  logic [31:0]       writedata;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              irq;

  logic [DATA_W-1:0] exp_q[$];
  int  m_used;
  bit  m_ovf;
  bit  ign;
  int  n_cmp;
  int  n_err;

  q_sys_out_fifo_feed #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .read      (read),
    .writedata (writedata),
    .readdata  (readdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .irq       (irq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; before the edge, check the stream against the model and update the model.
  task automatic step();
    bit full_before, is_flush, is_push, exp_valid;
    #1;
    if (ign) begin
      ign = 1'b0;
    end else begin
      is_flush    = write && (address == 2'd3) && writedata[0];
      is_push     = write && (address == 2'd0);
      full_before = (m_used == DEPTH);
      exp_valid   = (m_used != 0);
      n_cmp++;
      if (out_valid !== exp_valid) begin
        n_err++;
        $display("FAIL out_valid: got %b expected %b (t=%0t)", out_valid, exp_valid, $time);
      end
      if (is_flush) begin
        exp_q.delete();
        m_used = 0;
        m_ovf  = 1'b0;
      end else begin
        if (exp_valid && out_ready) begin
          n_cmp++;
          if (out_data !== exp_q[0]) begin
            n_err++;
            $display("FAIL stream_data: got %h expected %h (t=%0t)", out_data, exp_q[0], $time);
          end
          void'(exp_q.pop_front());
          m_used--;
        end
        if (is_push) begin
          if (full_before) m_ovf = 1'b1;
          else begin
            exp_q.push_back(writedata[DATA_W-1:0]);
            m_used++;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1'b1;
    step();
    read = 1'b0;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (readdata !== 32'd0) begin n_err++; $display("FAIL rst_readdata: got %h expected 0", readdata); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (irq !== 1'b0)       begin n_err++; $display("FAIL rst_irq: got %b expected 0", irq); end
    reset = 1'b0;
    ign = 1'b1;
    step();
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0001_0000) begin n_err++; $display("FAIL rst_status: got %h expected 00010000", d); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rst_ctrl: got %h expected 0", d); end
    bus_read(2'd0, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL data_read: got %h expected 0", d); end
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'hA1; vals[1] = 32'hA2; vals[2] = 32'hA3;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus_write(2'd0, vals[i]);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== vals[i]) begin
        n_err++;
        $display("FAIL stream_head%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, vals[i]);
      end
    end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drained: got %b expected 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) bus_write(2'd0, $urandom);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0002_0010) begin n_err++; $display("FAIL ovf_full_status: got %h expected 00020010", d); end
    bus_write(2'd0, 32'hDEAD_0017);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0006_0010) begin n_err++; $display("FAIL ovf_status: got %h expected 00060010", d); end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0006_0010) begin n_err++; $display("FAIL ovf_sticky: got %h expected 00060010", d); end
    out_ready = 1'b1;
    repeat (DEPTH + 1) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drained: got %b expected 0", out_valid); end
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0005_0000) begin n_err++; $display("FAIL ovf_empty_status: got %h expected 00050000", d); end
    out_ready = 1'b0;
    bus_write(2'd3, 32'd1);
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0001_0000) begin n_err++; $display("FAIL ovf_flush_clear: got %h expected 00010000", d); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) bus_write(2'd0, 32'h3600_0000 + i);
    address = 2'd0; writedata = 32'hBAD0_0036; write = 1'b1; out_ready = 1'b1;
    step();
    write = 1'b0; out_ready = 1'b0;
    bus_read(2'd1, d);
    n_cmp++; if (d[18] !== 1'b1) begin n_err++; $display("FAIL fpp_overflow: got %b expected 1", d[18]); end
    n_cmp++; if (d[16] !== 1'b0) begin n_err++; $display("FAIL fpp_empty: got %b expected 0", d[16]); end
    out_ready = 1'b1;
    repeat (DEPTH + 1) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fpp_drained: got %b expected 0", out_valid); end
    out_ready = 1'b0;
    bus_write(2'd3, 32'd1);
  endtask

  task automatic test_irq();
    logic [31:0] d;
    out_ready = 1'b0;
    bus_write(2'd2, 32'h0000_0102);
    step();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_empty: got %b expected 1", irq); end
    for (int i = 0; i < 4; i++) bus_write(2'd0, 32'h7700 + i);
    step();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_at4: got %b expected 0", irq); end
    out_ready = 1'b1;
    step();
    step();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_used2_same: got %b expected 0", irq); end
    step();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL irq_rise: got %b expected 1", irq); end
    step();
    out_ready = 1'b0;
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'h0000_0102) begin n_err++; $display("FAIL irq_ctrl_read: got %h expected 00000102", d); end
    bus_write(2'd2, 32'd0);
    step();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL irq_disable: got %b expected 0", irq); end
  endtask

  task automatic test_flush_pop();
    logic [31:0] d;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) bus_write(2'd0, 32'h5500 + i);
    address = 2'd3; writedata = 32'd1; write = 1'b1; out_ready = 1'b1;
    step();
    write = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", out_valid); end
    out_ready = 1'b0;
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0001_0000) begin n_err++; $display("FAIL flush_status: got %h expected 00010000", d); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, exp_s;
    bus_write(2'd3, 32'd1);
    for (int i = 0; i < 150; i++) begin
      address   = 2'd0;
      writedata = $urandom;
      write     = ($urandom_range(0, 2) != 0);
      out_ready = $urandom_range(0, 1);
      step();
    end
    write = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) step();
    exp_s = '0;
    exp_s[8:0] = 9'(m_used);
    exp_s[16]  = (m_used == 0);
    exp_s[17]  = (m_used == DEPTH);
    exp_s[18]  = m_ovf;
    bus_read(2'd1, d);
    n_cmp++; if (d !== exp_s) begin n_err++; $display("FAIL b2b_status: got %h expected %h", d, exp_s); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) bus_write(2'd0, 32'h8800 + i);
    bus_write(2'd2, 32'h0000_01FF);
    step();
    n_cmp++; if (irq !== 1'b1) begin n_err++; $display("FAIL rm_irq_before: got %b expected 1", irq); end
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rm_valid: got %b expected 0", out_valid); end
    n_cmp++; if (irq !== 1'b0)       begin n_err++; $display("FAIL rm_irq: got %b expected 0", irq); end
    exp_q.delete();
    m_used = 0;
    m_ovf  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    address = 2'd0; writedata = 32'h5A5A_5A5A; write = 1'b1; out_ready = 1'b1;
    ign = 1'b1;
    step();
    write = 1'b0;
    bus_read(2'd1, d);
    n_cmp++; if (d !== 32'h0001_0000) begin n_err++; $display("FAIL rm_status: got %h expected 00010000", d); end
    bus_read(2'd2, d);
    n_cmp++; if (d !== 32'd0) begin n_err++; $display("FAIL rm_ctrl: got %h expected 0", d); end
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; write = 1'b0; read = 1'b0; writedata = '0; out_ready = 1'b0;
    m_used = 0; m_ovf = 1'b0; ign = 1'b0; n_cmp = 0; n_err = 0;
    test_reset();
    test_stream();
    test_overflow();
    test_full_push_pop();
    test_irq();
    test_flush_pop();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
